fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 175 +++++++++++++++++
 tb/tb_fetch_unit.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues single outstanding imem requests, tracks
// redirects while a request is in flight, and feeds the IF/ID register via a
// one-entry holding buffer when decode cannot accept a returning word.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        StallF,
    input  logic        StallD,
    input  logic        FlushD,
    input  logic        PCSrcE,
    input  logic [31:0] PCTargetE,
    output logic        ImemReq,
    output logic [31:0] ImemAddr,
    input  logic        ImemValid,
    input  logic [31:0] ImemRdata,
    output logic [31:0] InstrD,
    output logic [31:0] PCD,
    output logic [31:0] PCPlus4D,
    output logic        ValidD,
    output logic        FetchBusy
);

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t      state_r;
    state_t      state_next_s;
    logic        issue_s;
    logic        accept_s;

    logic [31:0] pcf_r;
    logic [31:0] req_pc_r;
    logic [31:0] buf_instr_r;
    logic [31:0] buf_pc_r;
    logic        buf_full_r;

    logic [31:0] instr_d_r;
    logic [31:0] pc_d_r;
    logic [31:0] pc_plus4_d_r;
    logic        valid_d_r;

    // Next-state logic plus the issue/accept decisions for this cycle.
    always_comb begin
        state_next_s = state_r;
        issue_s      = 1'b0;
        accept_s     = 1'b0;
        case (state_r)
            IDLE: begin
                // A response arriving here belongs to an abandoned request and is ignored.
                if (!buf_full_r && !StallF && !PCSrcE && !reset) begin
                    issue_s      = 1'b1;
                    state_next_s = WAIT;
                end else begin
                    state_next_s = IDLE;
                end
            end
            WAIT: begin
                if (ImemValid) begin
                    // A redirect in the same cycle turns the response into a dropped word.
                    accept_s     = !PCSrcE;
                    state_next_s = IDLE;
                end else if (PCSrcE) begin
                    state_next_s = DRAIN;
                end else begin
                    state_next_s = WAIT;
                end
            end
            DRAIN: begin
                if (ImemValid) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = DRAIN;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Fetch FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Fetch PC, outstanding-request PC and the one-entry holding buffer.
    always_ff @(posedge clk) begin
        if (reset) begin
            pcf_r       <= RESET_PC;
            req_pc_r    <= RESET_PC;
            buf_instr_r <= 32'h0000_0000;
            buf_pc_r    <= 32'h0000_0000;
            buf_full_r  <= 1'b0;
        end else begin
            if (issue_s) begin
                req_pc_r <= pcf_r;
            end else begin
                req_pc_r <= req_pc_r;
            end

            if (PCSrcE) begin
                pcf_r <= PCTargetE;
            end else if (accept_s) begin
                pcf_r <= req_pc_r + 32'd4;
            end else begin
                pcf_r <= pcf_r;
            end

            if (PCSrcE) begin
                buf_full_r <= 1'b0;
            end else if (accept_s && (StallD || FlushD)) begin
                buf_instr_r <= ImemRdata;
                buf_pc_r    <= req_pc_r;
                buf_full_r  <= 1'b1;
            end else if (buf_full_r && !FlushD && !StallD) begin
                // Buffered word moves into IF/ID this cycle.
                buf_full_r <= 1'b0;
            end else begin
                buf_full_r <= buf_full_r;
            end
        end
    end

    // IF/ID pipeline register: flush, hold, buffered word, fresh word, or bubble.
    always_ff @(posedge clk) begin
        if (reset) begin
            instr_d_r    <= NOP_INSTR;
            pc_d_r       <= 32'h0000_0000;
            pc_plus4_d_r <= 32'h0000_0000;
            valid_d_r    <= 1'b0;
        end else if (FlushD) begin
            instr_d_r <= NOP_INSTR;
            valid_d_r <= 1'b0;
        end else if (StallD) begin
            instr_d_r    <= instr_d_r;
            pc_d_r       <= pc_d_r;
            pc_plus4_d_r <= pc_plus4_d_r;
            valid_d_r    <= valid_d_r;
        end else if (buf_full_r) begin
            instr_d_r    <= buf_instr_r;
            pc_d_r       <= buf_pc_r;
            pc_plus4_d_r <= buf_pc_r + 32'd4;
            valid_d_r    <= 1'b1;
        end else if (accept_s) begin
            instr_d_r    <= ImemRdata;
            pc_d_r       <= req_pc_r;
            pc_plus4_d_r <= req_pc_r + 32'd4;
            valid_d_r    <= 1'b1;
        end else begin
            instr_d_r <= NOP_INSTR;
            valid_d_r <= 1'b0;
        end
    end

    // The request strobe must rise in the same cycle the fetch is allowed.
    assign ImemReq   = issue_s;
    assign ImemAddr  = pcf_r;
    assign InstrD    = instr_d_r;
    assign PCD       = pc_d_r;
    assign PCPlus4D  = pc_plus4_d_r;
    assign ValidD    = valid_d_r;
    assign FetchBusy = (state_r != IDLE);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a per-cycle vector table with a small
// latency-programmable memory responder, plus hand sequences for reset
// during an outstanding request and address wrap.
module tb_fetch_unit;

    logic        clk;
    logic        reset;
    logic        StallF, StallD, FlushD, PCSrcE;
    logic [31:0] PCTargetE;
    logic        ImemReq;
    logic [31:0] ImemAddr;
    logic        ImemValid;
    logic [31:0] ImemRdata;
    logic [31:0] InstrD, PCD, PCPlus4D;
    logic        ValidD, FetchBusy;

    localparam logic [31:0] NOP = 32'h0000_0013;

    int total = 0;
    int bad   = 0;

    // memory responder state
    logic        pend      = 1'b0;
    logic [31:0] pend_addr = 32'h0;
    int          pend_cnt  = 0;
    logic        seen_req;
    logic [31:0] seen_addr;

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .reset(reset),
        .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
        .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
        .ImemReq(ImemReq), .ImemAddr(ImemAddr),
        .ImemValid(ImemValid), .ImemRdata(ImemRdata),
        .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
        .ValidD(ValidD), .FetchBusy(FetchBusy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] wd(input logic [31:0] a);
        return a ^ 32'h5A00_0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock: deliver any due response, drive controls, observe request, advance.
    task automatic cycle(input logic stf, input logic std, input logic fld, input logic pcs,
                         input logic [31:0] tgt, input int lat, input logic rst_v);
        ImemValid = 1'b0;
        ImemRdata = 32'h0;
        if (pend) begin
            if (pend_cnt == 0) begin
                ImemValid = 1'b1;
                ImemRdata = wd(pend_addr);
                pend      = 1'b0;
            end else begin
                pend_cnt--;
            end
        end
        reset = rst_v; StallF = stf; StallD = std; FlushD = fld;
        PCSrcE = pcs; PCTargetE = tgt;
        #1;
        seen_req  = ImemReq;
        seen_addr = ImemAddr;
        if (ImemReq) begin
            pend      = 1'b1;
            pend_addr = ImemAddr;
            pend_cnt  = lat - 1;
        end
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        stf, std, fld, pcs;
        logic [31:0] tgt;
        int          lat;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_pcd;
        logic        e_busy;
    } vec_t;

    function automatic vec_t v(input logic stf, input logic std, input logic fld,
                               input logic pcs, input logic [31:0] tgt, input int lat,
                               input logic e_req, input logic [31:0] e_addr,
                               input logic e_valid, input logic [31:0] e_pcd,
                               input logic e_busy);
        vec_t r;
        r.stf = stf; r.std = std; r.fld = fld; r.pcs = pcs; r.tgt = tgt; r.lat = lat;
        r.e_req = e_req; r.e_addr = e_addr; r.e_valid = e_valid; r.e_pcd = e_pcd;
        r.e_busy = e_busy;
        return r;
    endfunction

    vec_t tbl[28];

    initial begin
        //            stf  std  fld  pcs  tgt           lat req addr         vld pcd          busy
        // sequential fetch, 1-cycle memory
        tbl[0]  = v(1'b0,1'b0,1'b0,1'b0,32'h0,        1, 1'b1,32'h0000_0000,1'b0,32'h0,       1'b1);
        tbl[1]  = v(1'b0,1'b0,1'b0,1'b0,32'h0,        1, 1'b0,32'h0,        1'b1,32'h0000_0000,1'b0);
        tbl[2]  = v(1'b0,1'b0,1'b0,1'b0,32'h0,        1, 1'b1,32'h0000_0004,1'b0,32'h0,       1'b1);
        tbl[3]  = v(1'b0,1'b0,1'b0,1'b0,32'h0,        1, 1'b0,32'h0,        1'b1,32'h0000_0004,1'b0);
        // StallD for 3 cycles across the response for 0x8
        tbl[4]  = v(1'b0,1'b1,1'b0,1'b0,32'h0,        1, 1'b1,32'h0000_0008,1'b1,32'h0000_0004,1'b1);
        tbl[5]  = v(1'b0,1'b1,1'b0,1'b0,32'h0,        1, 1'b0,32'h0,        1'b1,32'h0000_0004,1'b0);
        tbl[6]  = v(1'b0,1'b1,1'b0,1'b0,32'h0,        1, 1'b0,32'h0,        1'b1,32'h0000_0004,1'b0);
        tbl[7]  = v(1'b0,1'b0,1'b0,1'b0,32'h0,        1, 1'b0,32'h0,        1'b1,32'h0000_0008,1'b0);
        tbl[8]  = v(1'b0,1'b0,1'b0,1'b0,32'h0,        1, 1'b1,32'h0000_000C,1'b0,32'h0,       1'b1);
        tbl[9]  = v(1'b0,1'b0,1'b0,1'b0,32'h0,        1, 1'b0,32'h0,        1'b1,32'h0000_000C,1'b0);
        // redirect during WAIT, slow response dropped in DRAIN
        tbl[10] = v(1'b0,1'b0,1'b0,1'b0,32'h0,        3, 1'b1,32'h0000_0010,1'b0,32'h0,       1'b1);
        tbl[11] = v(1'b0,1'b0,1'b0,1'b1,32'h0000_0100,1, 1'b0,32'h0,        1'b0,32'h0,       1'b1);
        tbl[12] = v(1'b0,1'b0,1'b0,1'b0,32'h0,        1, 1'b0,32'h0,        1'b0,32'h0,       1'b1);
        tbl[13] = v(1'b0,1'b0,1'b0,1'b0,32'h0,        1, 1'b0,32'h0,        1'b0,32'h0,       1'b0);
        tbl[14] = v(1'b0,1'b0,1'b0,1'b0,32'h0,        1, 1'b1,32'h0000_0100,1'b0,32'h0,       1'b1);
        tbl[15] = v(1'b0,1'b0,1'b0,1'b0,32'h0,        1, 1'b0,32'h0,        1'b1,32'h0000_0100,1'b0);
        // buffered word, then redirect with flush
        tbl[16] = v(1'b0,1'b1,1'b0,1'b0,32'h0,        1, 1'b1,32'h0000_0104,1'b1,32'h0000_0100,1'b1);
        tbl[17] = v(1'b0,1'b1,1'b0,1'b0,32'h0,        1, 1'b0,32'h0,        1'b1,32'h0000_0100,1'b0);
        tbl[18] = v(1'b0,1'b0,1'b1,1'b1,32'h0000_0200,1, 1'b0,32'h0,        1'b0,32'h0,       1'b0);
        tbl[19] = v(1'b0,1'b0,1'b0,1'b0,32'h0,        1, 1'b1,32'h0000_0200,1'b0,32'h0,       1'b1);
        tbl[20] = v(1'b0,1'b0,1'b0,1'b0,32'h0,        1, 1'b0,32'h0,        1'b1,32'h0000_0200,1'b0);
        // StallF blocks issue but not acceptance
        tbl[21] = v(1'b1,1'b0,1'b0,1'b0,32'h0,        1, 1'b0,32'h0,        1'b0,32'h0,       1'b0);
        tbl[22] = v(1'b0,1'b0,1'b0,1'b0,32'h0,        1, 1'b1,32'h0000_0204,1'b0,32'h0,       1'b1);
        tbl[23] = v(1'b1,1'b0,1'b0,1'b0,32'h0,        1, 1'b0,32'h0,        1'b1,32'h0000_0204,1'b0);
        // FlushD on the response cycle buffers the word, which survives the flush
        tbl[24] = v(1'b0,1'b0,1'b0,1'b0,32'h0,        1, 1'b1,32'h0000_0208,1'b0,32'h0,       1'b1);
        tbl[25] = v(1'b0,1'b0,1'b1,1'b0,32'h0,        1, 1'b0,32'h0,        1'b0,32'h0,       1'b0);
        tbl[26] = v(1'b0,1'b0,1'b0,1'b0,32'h0,        1, 1'b0,32'h0,        1'b1,32'h0000_0208,1'b0);
        // request left outstanding for the reset sequence below
        tbl[27] = v(1'b0,1'b0,1'b0,1'b0,32'h0,        2, 1'b1,32'h0000_020C,1'b0,32'h0,       1'b1);

        reset = 1'b1; StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0; PCSrcE = 1'b0;
        PCTargetE = 32'h0; ImemValid = 1'b0; ImemRdata = 32'h0;
        @(posedge clk); #1;

        // reset state
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1, 1'b1);
        chk("rst_req",      {31'h0, seen_req}, 32'h0);
        chk("rst_valid",    {31'h0, ValidD},   32'h0);
        chk("rst_instr",    InstrD,            NOP);
        chk("rst_pcd",      PCD,               32'h0);
        chk("rst_pcplus4",  PCPlus4D,          32'h0);
        chk("rst_busy",     {31'h0, FetchBusy}, 32'h0);

        for (int i = 0; i < 28; i++) begin
            cycle(tbl[i].stf, tbl[i].std, tbl[i].fld, tbl[i].pcs, tbl[i].tgt, tbl[i].lat, 1'b0);
            chk($sformatf("v%0d_req", i), {31'h0, seen_req}, {31'h0, tbl[i].e_req});
            if (tbl[i].e_req)
                chk($sformatf("v%0d_addr", i), seen_addr, tbl[i].e_addr);
            chk($sformatf("v%0d_valid", i), {31'h0, ValidD}, {31'h0, tbl[i].e_valid});
            chk($sformatf("v%0d_busy", i), {31'h0, FetchBusy}, {31'h0, tbl[i].e_busy});
            if (tbl[i].e_valid) begin
                chk($sformatf("v%0d_pcd", i), PCD, tbl[i].e_pcd);
                chk($sformatf("v%0d_instr", i), InstrD, wd(tbl[i].e_pcd));
                chk($sformatf("v%0d_pc4", i), PCPlus4D, tbl[i].e_pcd + 32'd4);
            end else begin
                chk($sformatf("v%0d_nop", i), InstrD, NOP);
            end
        end

        // reset while the 0x20C request is outstanding
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1, 1'b1);
        chk("mid_rst_busy",  {31'h0, FetchBusy}, 32'h0);
        chk("mid_rst_valid", {31'h0, ValidD},    32'h0);
        // stale response arrives in the first cycle after release
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1, 1'b0);
        chk("stale_vld_in",  {31'h0, ImemValid}, 32'h1);
        chk("post_rst_req",  {31'h0, seen_req},  32'h1);
        chk("post_rst_addr", seen_addr,          32'h0);
        chk("stale_valid",   {31'h0, ValidD},    32'h0);
        chk("stale_instr",   InstrD,             NOP);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1, 1'b0);
        chk("restart_valid", {31'h0, ValidD},    32'h1);
        chk("restart_pcd",   PCD,                32'h0);
        chk("restart_instr", InstrD,             wd(32'h0));

        // address wrap at the top of the space
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1, 1'b0);
        chk("wrap_redir_req", {31'h0, seen_req}, 32'h0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1, 1'b0);
        chk("wrap_req_addr", seen_addr,          32'hFFFF_FFFC);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1, 1'b0);
        chk("wrap_valid",    {31'h0, ValidD},    32'h1);
        chk("wrap_pcd",      PCD,                32'hFFFF_FFFC);
        chk("wrap_pcplus4",  PCPlus4D,           32'h0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1, 1'b0);
        chk("wrap_next_req",  {31'h0, seen_req}, 32'h1);
        chk("wrap_next_addr", seen_addr,         32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
